// File: rtl/matrix_load_ctrl.sv
// 16-byte matrix load controller; define MATRIX_LOAD_CTRL_TRANSPOSE_EN for column-major fill.
// Zero-latency byte write to element regs; in_ready drops outside LOAD or on abort.
module matrix_load_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        reg_clear,
   output logic [15:0] reg_en,
   output logic [7:0]  reg_d,
   output logic [3:0]  idx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_idx;
   logic [3:0] w_idx_next;
   logic [3:0] w_map;
   logic       w_xfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_next;
      end
   end

   // abort wins over start, transfer and completion in every state
   always_comb begin
      w_next     = r_state;
      w_idx_next = r_idx;
      in_ready   = 1'b0;
      reg_clear  = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            reg_clear  = 1'b1;
            w_idx_next = 4'd0;
            w_next     = abort ? S_IDLE : S_LOAD;
         end
         S_LOAD: begin
            in_ready = !abort;
            if (abort) begin
               w_next = S_IDLE;
            end else if (in_valid) begin
               w_idx_next = r_idx + 4'd1;
               if (r_idx == 4'd15) w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = !abort;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

`ifdef MATRIX_LOAD_CTRL_TRANSPOSE_EN
   assign w_map = {r_idx[1:0], r_idx[3:2]};
`else
   assign w_map = r_idx;
`endif

   assign w_xfer    = in_valid && in_ready;
   assign reg_en    = w_xfer ? (16'd1 << w_map) : 16'd0;
   assign reg_d     = in_data;
   assign idx       = r_idx;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Directed bench for matrix_load_ctrl; inputs change 1 ns after the rising edge, outputs checked 1 ns later.
module tb_matrix_load_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reg_clear;
   logic [15:0] reg_en;
   logic [7:0]  reg_d;
   logic [3:0]  idx;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int c0;

`ifdef MATRIX_LOAD_CTRL_TRANSPOSE_EN
   localparam logic TP = 1'b1;
`else
   localparam logic TP = 1'b0;
`endif

   always #5 clk = ~clk;

   matrix_load_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reg_clear (reg_clear),
      .reg_en    (reg_en),
      .reg_d     (reg_d),
      .idx       (idx),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [3:0] map_idx(input logic [3:0] i);
      return TP ? {i[1:0], i[3:2]} : i;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_idle(input string tag);
      #1;
      chk({tag, "_busy"},  16'(busy), 16'd0);
      chk({tag, "_done"},  16'(done), 16'd0);
      chk({tag, "_rdy"},   16'(in_ready), 16'd0);
      chk({tag, "_clr"},   16'(reg_clear), 16'd0);
      chk({tag, "_en"},    reg_en, 16'd0);
   endtask

   // drive start for one edge, confirm CLEAR, then step into LOAD
   task automatic start_load(input string tag);
      start = 1'b1;
      c0    = cyc;
      tick();
      start = 1'b0;
      #1;
      chk({tag, "_clear"}, 16'(reg_clear), 16'd1);
      chk({tag, "_busy"},  16'(busy), 16'd1);
      chk({tag, "_clr_rdy"}, 16'(in_ready), 16'd0);
      tick();
   endtask

   task automatic xfer(input string tag, input logic [7:0] d, input logic [3:0] exp_idx);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk({tag, "_idx"}, 16'(idx), 16'(exp_idx));
      chk({tag, "_en"},  reg_en, 16'd1 << map_idx(exp_idx));
      chk({tag, "_d"},   16'(reg_d), 16'(d));
      chk({tag, "_clr"}, 16'(reg_clear), 16'd0);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      chk_idle("reset");
      chk("reset_idx", 16'(idx), 16'd0);
      #10 reset_n = 1'b1;
      tick();
      chk_idle("post_reset");

      // full row-major / column-major load with timing check on done
      start_load("full");
      for (int k = 0; k < 16; k++) begin
         if (k == 1) begin
            in_valid = 1'b1;
            in_data  = 8'h01;
            #1;
            chk("byte2_en", reg_en, TP ? 16'h0010 : 16'h0002);
         end
         if (k == 4) begin
            in_valid = 1'b1;
            in_data  = 8'h04;
            #1;
            chk("byte5_en", reg_en, TP ? 16'h0002 : 16'h0010);
         end
         xfer("full", 8'(k), 4'(k));
      end
      #1;
      chk("full_done", 16'(done), 16'd1);
      chk("full_done_lat", 16'(cyc - c0), 16'd18);
      chk("full_idx_wrap", 16'(idx), 16'd0);
      chk("full_done_rdy", 16'(in_ready), 16'd0);
      tick();
      chk_idle("full_after");

      // stalls: in_valid alternates 1,0,1,0...
      start_load("stall");
      begin
         logic [3:0] exp_i;
         exp_i = 4'd0;
         for (int c = 0; c < 31; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 8'hA0 + 8'(c);
            #1;
            chk("stall_idx", 16'(idx), 16'(exp_i));
            chk("stall_en", reg_en, in_valid ? (16'd1 << map_idx(exp_i)) : 16'd0);
            tick();
            if (c % 2 == 0) exp_i = exp_i + 4'd1;
         end
      end
      in_valid = 1'b0;
      #1;
      chk("stall_done", 16'(done), 16'd1);
      tick();
      chk_idle("stall_after");

      // abort at idx=7 with a valid byte present
      start_load("abort");
      for (int k = 0; k < 7; k++) xfer("abort_pre", 8'h30 + 8'(k), 4'(k));
      in_valid = 1'b1;
      in_data  = 8'h37;
      abort    = 1'b1;
      start    = 1'b1;
      #1;
      chk("abort_en", reg_en, 16'd0);
      chk("abort_rdy", 16'(in_ready), 16'd0);
      chk("abort_idx", 16'(idx), 16'd7);
      tick();
      abort    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      chk_idle("abort_idle");
      chk("abort_idx_hold", 16'(idx), 16'd7);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_idle("abort_quiet");
      end
      start_load("restart");
      xfer("restart", 8'h55, 4'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("restart_abort");

      // asynchronous reset mid-load at idx=10
      start_load("rst");
      for (int k = 0; k < 10; k++) xfer("rst_pre", 8'h60 + 8'(k), 4'(k));
      in_valid = 1'b1;
      in_data  = 8'h6A;
      #1;
      chk("rst_pre_idx", 16'(idx), 16'd10);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_busy", 16'(busy), 16'd0);
      chk("rst_async_rdy", 16'(in_ready), 16'd0);
      chk("rst_async_en", reg_en, 16'd0);
      chk("rst_async_idx", 16'(idx), 16'd0);
      chk("rst_async_done", 16'(done), 16'd0);
      #2 reset_n = 1'b1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_idle("rst_after");
      end

      // start held high across a load: re-entry only via IDLE
      start = 1'b1;
      tick();
      #1;
      chk("hold_clear", 16'(reg_clear), 16'd1);
      tick();
      for (int k = 0; k < 16; k++) xfer("hold", 8'hF0 + 8'(k), 4'(k));
      #1;
      chk("hold_done", 16'(done), 16'd1);
      tick();
      #1;
      chk("hold_idle_busy", 16'(busy), 16'd0);
      chk("hold_idle_clr", 16'(reg_clear), 16'd0);
      tick();
      #1;
      chk("hold_reclear", 16'(reg_clear), 16'd1);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("hold_end");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matrix_load_ctrl.md
MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-003 start  input  1  request to begin a 16-byte matrix load.
REQ-004 abort  input  1  cancels an active load.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_data  input  8  matrix element byte.
REQ-007 in_ready  output  1  controller accepts a byte this cycle.
REQ-008 reg_clear  output  1  clear pulse to all 16 element registers (active-high).
REQ-009 reg_en  output  16  one-hot write enable, one bit per 8-bit element register.
REQ-010 reg_d  output  8  data to the element registers.
REQ-011 idx  output  4  count of bytes accepted in the current load.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, CLEAR, LOAD and DONE.
REQ-015 In IDLE, start=1 with abort=0 SHALL move the FSM to CLEAR on the next edge; start SHALL be ignored in all other states.
REQ-016 CLEAR SHALL last exactly one cycle, assert reg_clear=1 and set idx=0, then move the FSM to LOAD.
REQ-017 In LOAD, in_ready SHALL be 1 when abort=0; it SHALL be 0 in every other state and whenever abort=1.
REQ-018 A transfer SHALL occur when in_valid and in_ready are both 1 in the same cycle.
REQ-019 During a transfer cycle, reg_en SHALL combinationally assert only bit map(idx) and reg_d SHALL equal in_data, so the element register captures the byte at that edge (zero added latency).
REQ-020 Outside transfer cycles, reg_en SHALL be all zero; reg_d SHALL equal in_data at all times.
REQ-021 idx SHALL increment by 1 on each transfer and hold when in_valid=0.
REQ-022 A transfer at idx=15 SHALL move the FSM to DONE; idx SHALL wrap to 0.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return the FSM to IDLE.
REQ-024 abort=1 in CLEAR, LOAD or DONE SHALL return the FSM to IDLE on the next edge, with these effects:
- no reg_en asserted in that cycle;
- done not asserted;
- register contents left as already written.
REQ-025 abort takes priority over a simultaneous transfer, start or idx=15 completion.
REQ-026 reg_clear SHALL be 0 in every state except CLEAR.

Reset
REQ-027 reset_n=0 SHALL immediately force the following, independent of clk:
- FSM to IDLE;
- idx=0;
- in_ready, reg_clear, busy and done to 0;
- reg_en to all zero.
REQ-028 Assertion of reset_n mid-LOAD SHALL discard the load; no done pulse SHALL follow reset release.

Configuration
REQ-029 When macro MATRIX_LOAD_CTRL_TRANSPOSE_EN is defined, map(idx) SHALL be {idx[1:0], idx[3:2]}, i.e. column-major fill.
REQ-030 When MATRIX_LOAD_CTRL_TRANSPOSE_EN is undefined, map(idx) SHALL equal idx, i.e. row-major fill.

Verification
REQ-031 Full load: start, then 16 consecutive valid bytes 0x00..0x0F.
- reg_clear is asserted for one cycle.
- reg_en walks bit0..bit15.
- done pulses once, 18 cycles after the start edge.
- busy then drops.
REQ-032 Stalls: in_valid toggled 1,0,1,0 during LOAD.
- idx advances only on valid cycles.
- reg_en is zero on stall cycles.
- done follows the 16th accepted byte.
REQ-033 Abort at idx=7 with in_valid=1.
- reg_en stays zero in that cycle.
- FSM returns to IDLE; done never pulses.
- A fresh start produces a new reg_clear.
REQ-034 reset_n pulled low at idx=10.
- All outputs go to 0 asynchronously.
- After release, busy=0 and done=0 until the next start.
REQ-035 With MATRIX_LOAD_CTRL_TRANSPOSE_EN defined, bytes 0x00..0x0F are loaded.
- The 2nd byte enables reg_en bit4.
- The 5th byte enables reg_en bit1.
REQ-036 start held high through a whole load.
- No second load begins until the FSM passes through IDLE.
- The next load begins exactly one cycle after DONE.
